// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with frame-synchronous capture,
// leading-zero blanking, per-digit decimal points and an anti-ghosting gap.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_hi,
    input  logic [7:0] bcd_lo,
    input  logic       blank_lz,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   digits_q, digits_d;
    logic          blz_q, blz_d;
    logic [3:0]    dpm_q, dpm_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          cnt_wrap;
    logic          capture;
    logic          lz3, lz2, lz1;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;

        // Inputs are only sampled at the start of a frame so a frame never mixes old and new digits
        capture  = (cnt_q == '0) && (idx_q == 2'd0);
        digits_d = capture ? {bcd_hi, bcd_lo} : digits_q;
        blz_d    = capture ? blank_lz : blz_q;
        dpm_d    = capture ? dp_mask : dpm_q;
        tick_d   = capture;

        lz3 = blz_q && (digits_q[15:12] == 4'd0);
        lz2 = lz3 && (digits_q[11:8] == 4'd0);
        lz1 = lz2 && (digits_q[7:4] == 4'd0);

        cur_digit = digits_q[3:0];
        cur_blank = 1'b0;
        case (idx_q)
            2'd0: begin cur_digit = digits_q[3:0];   cur_blank = 1'b0; end
            2'd1: begin cur_digit = digits_q[7:4];   cur_blank = lz1;  end
            2'd2: begin cur_digit = digits_q[11:8];  cur_blank = lz2;  end
            2'd3: begin cur_digit = digits_q[15:12]; cur_blank = lz3;  end
            default: ;
        endcase

        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (cnt_q >= CNT_GAP) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = cur_blank ? 7'h7F : decode(cur_digit);
            dp_d  = ~dpm_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            digits_q <= 16'h0000;
            blz_q    <= 1'b0;
            dpm_q    <= 4'b0000;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            blz_q    <= blz_d;
            dpm_q    <= dpm_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at REFRESH_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_seg7_scan_driver;

    logic       clk;
    logic       reset;
    logic [7:0] bcd_hi;
    logic [7:0] bcd_lo;
    logic       blank_lz;
    logic [3:0] dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int testCount;
    int failCount;

    typedef struct packed {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        blz;
        logic [3:0]  dpm;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpx;    // active-low dp per digit
    } vec_t;

    vec_t vecs [10];

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_hi     (bcd_hi),
        .bcd_lo     (bcd_lo),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo,
                                 input logic blz, input logic [3:0] dpm);
        bcd_hi   = hi;
        bcd_lo   = lo;
        blank_lz = blz;
        dp_mask  = dpm;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [12:0] got, input logic [12:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s step %0d: got an=%h seg=%h dp=%b tick=%b, expected an=%h seg=%h dp=%b tick=%b",
                     name, step, got[12:9], got[8:2], got[1], got[0],
                     exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // Expected outputs k cycles after the frame_tick cycle (k = 0 is the tick cycle itself)
    function automatic logic [12:0] expectAt(input int k, input logic [27:0] segs,
                                             input logic [3:0] dpx);
        int d;
        int c;
        logic [3:0] a;
        logic [6:0] s;
        logic p;
        d = k / 8;
        c = k % 8;
        if (c < 2) begin
            a = 4'b1111;
            s = 7'h7F;
            p = 1'b1;
        end else begin
            a = ~(4'b0001 << d);
            s = segs[d*7 +: 7];
            p = dpx[d];
        end
        return {a, s, p, (k == 0)};
    endfunction

    // Caller must already be at the negedge of step kFrom
    task automatic checkFrame(input string name, input int kFrom, input int kTo,
                              input logic [27:0] segs, input logic [3:0] dpx);
        for (int k = kFrom; k <= kTo; k++) begin
            if (k != kFrom) @(negedge clk);
            checkOutput(name, k, {an, seg, dp, frame_tick}, expectAt(k, segs, dpx));
        end
    endtask

    task automatic waitTick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        testCount++;
        if (!frame_tick) begin
            failCount++;
            $display("[TB] FAIL %s: frame_tick got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;

        vecs[0] = '{hi: 8'h12, lo: 8'h34, blz: 1'b0, dpm: 4'b0000,
                    segs: {7'h79, 7'h24, 7'h30, 7'h19}, dpx: 4'b1111};
        vecs[1] = '{hi: 8'h00, lo: 8'h07, blz: 1'b1, dpm: 4'b0000,
                    segs: {7'h7F, 7'h7F, 7'h7F, 7'h78}, dpx: 4'b1111};
        vecs[2] = '{hi: 8'h00, lo: 8'h00, blz: 1'b1, dpm: 4'b0000,
                    segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dpx: 4'b1111};
        vecs[3] = '{hi: 8'h05, lo: 8'h0A, blz: 1'b1, dpm: 4'b0100,
                    segs: {7'h7F, 7'h12, 7'h40, 7'h3F}, dpx: 4'b1011};
        vecs[4] = '{hi: 8'h00, lo: 8'h00, blz: 1'b0, dpm: 4'b1111,
                    segs: {7'h40, 7'h40, 7'h40, 7'h40}, dpx: 4'b0000};
        vecs[5] = '{hi: 8'hAB, lo: 8'hCD, blz: 1'b0, dpm: 4'b0000,
                    segs: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dpx: 4'b1111};
        vecs[6] = '{hi: 8'h0F, lo: 8'h00, blz: 1'b1, dpm: 4'b0000,
                    segs: {7'h7F, 7'h3F, 7'h40, 7'h40}, dpx: 4'b1111};
        vecs[7] = '{hi: 8'h00, lo: 8'h56, blz: 1'b1, dpm: 4'b1001,
                    segs: {7'h7F, 7'h7F, 7'h12, 7'h02}, dpx: 4'b0110};
        vecs[8] = '{hi: 8'h78, lo: 8'h90, blz: 1'b0, dpm: 4'b0000,
                    segs: {7'h78, 7'h00, 7'h10, 7'h40}, dpx: 4'b1111};
        vecs[9] = '{hi: 8'h01, lo: 8'h00, blz: 1'b1, dpm: 4'b0010,
                    segs: {7'h7F, 7'h79, 7'h40, 7'h40}, dpx: 4'b1101};

        // Reset held for three cycles: outputs must sit at their idle values
        reset = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", i, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        reset = 1'b0;
        @(negedge clk);
        checkFrame("post_reset_frame", 0, 31, vecs[0].segs, vecs[0].dpx);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].hi, vecs[v].lo, vecs[v].blz, vecs[v].dpm);
            waitTick($sformatf("vec%0d_tick", v));
            checkFrame($sformatf("vec%0d", v), 0, 31, vecs[v].segs, vecs[v].dpx);
        end

        // Input change mid-frame must not show until the following capture
        applyStimulus(8'h11, 8'h11, 1'b0, 4'b0000);
        waitTick("midframe_tick");
        checkFrame("midframe_before", 0, 15, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);
        @(negedge clk);
        applyStimulus(8'h11, 8'h99, 1'b0, 4'b0000);
        checkFrame("midframe_hold", 16, 31, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);
        waitTick("midframe_next_tick");
        checkFrame("midframe_after", 0, 31, {7'h79, 7'h79, 7'h10, 7'h10}, 4'b1111);

        // Reset during the digit3 lit slot, then restart with new inputs
        applyStimulus(8'h12, 8'h34, 1'b0, 4'b0000);
        waitTick("midreset_tick");
        checkFrame("midreset_pre", 0, 28, vecs[0].segs, vecs[0].dpx);
        reset = 1'b1;
        applyStimulus(8'h78, 8'h90, 1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("midreset_idle", 0, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        checkOutput("midreset_idle", 1, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        checkFrame("midreset_restart", 0, 31, vecs[8].segs, vecs[8].dpx);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
